// File: rtl/minero_hash_iterativo_if.sv
// Host-side bundle for the iterative nonce-search engine: start/abort
// controls, latched search inputs, and held search results.
interface minero_hash_iterativo_if #(
   parameter int NONCE_W = 32,
   parameter int DATA_W  = 128 - NONCE_W
);
   logic               inicio;
   logic               detener;
   logic [DATA_W-1:0]  bloque_datos;
   logic [NONCE_W-1:0] nonce_inicio;
   logic [7:0]         target;
   logic               modo;
   logic               ocupado;
   logic               terminado;
   logic               encontrado;
   logic [23:0]        bounty;
   logic [NONCE_W-1:0] nonce_final;

   modport master (
      output inicio, detener, bloque_datos, nonce_inicio, target, modo,
      input  ocupado, terminado, encontrado, bounty, nonce_final
   );

   modport slave (
      input  inicio, detener, bloque_datos, nonce_inicio, target, modo,
      output ocupado, terminado, encontrado, bounty, nonce_final
   );
endinterface

// File: rtl/minero_hash_iterativo.sv
// Iterative micro-UCR nonce search: one W expansion per nonce, one hash
// round per clock, then a threshold compare. Stops on the first hit, when
// the last nonce has been tried, or on abort.
module minero_hash_iterativo #(
   parameter int                 NONCE_W   = 32,
   parameter int                 DATA_W    = 128 - NONCE_W,
   parameter logic [NONCE_W-1:0] NONCE_MAX = {NONCE_W{1'b1}},
   parameter int                 ROUNDS    = 32
) (
   input logic                    clk,
   input logic                    reset,
   minero_hash_iterativo_if.slave bus
);

   localparam int RW = $clog2(ROUNDS);
   localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);
   localparam logic [RW-1:0] SWITCH_RND = RW'(ROUNDS / 2);

   typedef logic [ROUNDS-1:0][7:0] w_t;
   typedef enum logic [1:0] {IDLE, LOAD, HASH, CHECK} state_t;

   state_t             state;
   logic [DATA_W-1:0]  datos_q;
   logic [NONCE_W-1:0] nonce_q;
   logic [7:0]         target_q;
   logic               modo_q;
   w_t                 w_q;
   logic [7:0]         a_q, b_q, c_q;
   logic [RW-1:0]      round_q;

   logic [127:0]       bloque;
   logic [23:0]        h;
   logic               hit;
   logic [7:0]         x_val;
   logic [7:0]         k_val;

   // Byte schedule: the first 16 words are the block bytes, the rest mix
   // earlier words so later rounds depend on the whole block.
   function automatic w_t expand(input logic [127:0] blk);
      w_t w;
      w = '0;
      for (int i = 0; i < 16; i++) begin
         w[i] = blk[8*i +: 8];
      end
      for (int i = 16; i < ROUNDS; i++) begin
         w[i] = w[i-3] | (w[i-9] ^ w[i-14]);
      end
      return w;
   endfunction

   assign bloque = {datos_q, nonce_q};
   assign h      = {8'hFE + c_q, 8'h89 + b_q, 8'h01 + a_q};
   assign hit    = (h[15:8] < target_q) && (h[23:16] < target_q) &&
                   (!modo_q || (h[7:0] < target_q));
   assign x_val  = (round_q <= SWITCH_RND) ? (a_q ^ b_q) : (a_q | b_q);
   assign k_val  = (round_q <= SWITCH_RND) ? 8'h99 : 8'hA1;

   // Search sequencer; abort outranks every transition and leaves the held
   // results untouched, and terminado only pulses on a real completion.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= IDLE;
         datos_q         <= '0;
         nonce_q         <= '0;
         target_q        <= '0;
         modo_q          <= 1'b0;
         w_q             <= '0;
         a_q             <= '0;
         b_q             <= '0;
         c_q             <= '0;
         round_q         <= '0;
         bus.ocupado     <= 1'b0;
         bus.terminado   <= 1'b0;
         bus.encontrado  <= 1'b0;
         bus.bounty      <= '0;
         bus.nonce_final <= '0;
      end else begin
         bus.terminado <= 1'b0;
         if ((state != IDLE) && bus.detener) begin
            state       <= IDLE;
            bus.ocupado <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (bus.inicio && !bus.detener) begin
                     datos_q        <= bus.bloque_datos;
                     nonce_q        <= bus.nonce_inicio;
                     target_q       <= bus.target;
                     modo_q         <= bus.modo;
                     bus.encontrado <= 1'b0;
                     bus.bounty     <= '0;
                     bus.ocupado    <= 1'b1;
                     state          <= LOAD;
                  end
               end
               LOAD: begin
                  w_q     <= expand(bloque);
                  a_q     <= 8'h01;
                  b_q     <= 8'h89;
                  c_q     <= 8'hFE;
                  round_q <= '0;
                  state   <= HASH;
               end
               HASH: begin
                  a_q     <= b_q ^ c_q;
                  b_q     <= {c_q[3:0], 4'h0};
                  c_q     <= x_val + k_val + w_q[round_q];
                  round_q <= round_q + RW'(1);
                  if (round_q == LAST_ROUND) begin
                     state <= CHECK;
                  end
               end
               CHECK: begin
                  if (hit) begin
                     bus.encontrado  <= 1'b1;
                     bus.bounty      <= h;
                     bus.nonce_final <= nonce_q;
                     bus.terminado   <= 1'b1;
                     bus.ocupado     <= 1'b0;
                     state           <= IDLE;
                  end else if (nonce_q == NONCE_MAX) begin
                     bus.encontrado  <= 1'b0;
                     bus.bounty      <= '0;
                     bus.nonce_final <= nonce_q;
                     bus.terminado   <= 1'b1;
                     bus.ocupado     <= 1'b0;
                     state           <= IDLE;
                  end else begin
                     nonce_q <= nonce_q + NONCE_W'(1);
                     state   <= LOAD;
                  end
               end
               default: begin
                  state       <= IDLE;
                  bus.ocupado <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_minero_hash_iterativo.sv
// Bench for minero_hash_iterativo: a 32-bit-nonce build and an 8-bit-nonce
// build, both compared against a search model computed from the hash rules.
module tb_minero_hash_iterativo;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic inicio = 1'b0;
   logic detener = 1'b0;
   logic modo_in = 1'b0;
   logic use8 = 1'b0;
   logic [127:0] data_in = '0;
   logic [31:0] nonce_in = '0;
   logic [7:0] target_in = '0;
   logic [31:0] last_nf32 = '0;
   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   minero_hash_iterativo_if #(.NONCE_W(32), .DATA_W(96))  bus32();
   minero_hash_iterativo_if #(.NONCE_W(8),  .DATA_W(120)) bus8();

   assign bus32.inicio       = inicio & ~use8;
   assign bus32.detener      = detener & ~use8;
   assign bus32.bloque_datos = data_in[95:0];
   assign bus32.nonce_inicio = nonce_in;
   assign bus32.target       = target_in;
   assign bus32.modo         = modo_in;
   assign bus8.inicio        = inicio & use8;
   assign bus8.detener       = detener & use8;
   assign bus8.bloque_datos  = data_in[119:0];
   assign bus8.nonce_inicio  = nonce_in[7:0];
   assign bus8.target        = target_in;
   assign bus8.modo          = modo_in;

   minero_hash_iterativo #(.NONCE_W(32), .DATA_W(96)) dut32 (
      .clk(clk), .reset(reset), .bus(bus32)
   );
   minero_hash_iterativo #(.NONCE_W(8), .DATA_W(120)) dut8 (
      .clk(clk), .reset(reset), .bus(bus8)
   );

   logic term_v, ocup_v, enc_v;
   logic [23:0] bounty_v;
   logic [31:0] nf_v;
   assign term_v   = use8 ? bus8.terminado : bus32.terminado;
   assign ocup_v   = use8 ? bus8.ocupado : bus32.ocupado;
   assign enc_v    = use8 ? bus8.encontrado : bus32.encontrado;
   assign bounty_v = use8 ? bus8.bounty : bus32.bounty;
   assign nf_v     = use8 ? {24'h0, bus8.nonce_final} : bus32.nonce_final;

   // Hash of one 128-bit block, straight from the round rules
   function automatic logic [23:0] model_hash(input logic [127:0] blk);
      logic [7:0] w [32];
      logic [7:0] a, b, c, na, nb, nc;
      for (int i = 0; i < 16; i++) w[i] = blk[8*i +: 8];
      for (int i = 16; i < 32; i++) w[i] = w[i-3] | (w[i-9] ^ w[i-14]);
      a = 8'h01; b = 8'h89; c = 8'hFE;
      for (int i = 0; i < 32; i++) begin
         na = b ^ c;
         nb = c << 4;
         if (i <= 16) nc = (a ^ b) + 8'h99 + w[i];
         else         nc = (a | b) + 8'hA1 + w[i];
         a = na; b = nb; c = nc;
      end
      return {8'hFE + c, 8'h89 + b, 8'h01 + a};
   endfunction

   // Whole-search outcome; tries > limit means "too long for this bench"
   function automatic void model_search(input int nw, input logic [127:0] data,
         input logic [31:0] start, input logic [7:0] tgt, input logic md, input int limit,
         output logic found, output logic [23:0] h_out, output logic [31:0] nf, output int tries);
      logic [31:0] maxn, n;
      logic [23:0] hv;
      logic [127:0] blk;
      maxn = (nw == 32) ? 32'hFFFF_FFFF : ((32'd1 << nw) - 32'd1);
      n = start & maxn;
      found = 1'b0; h_out = '0; nf = '0; tries = 0;
      while (tries < limit) begin
         tries++;
         blk = (data << nw) | {96'h0, n};
         hv = model_hash(blk);
         if (hv[15:8] < tgt && hv[23:16] < tgt && (!md || hv[7:0] < tgt)) begin
            found = 1'b1; h_out = hv; nf = n;
            return;
         end
         if (n == maxn) begin
            nf = n;
            return;
         end
         n++;
      end
      tries = limit + 1;
   endfunction

   // Pulse inicio for the start edge, then count edges until terminado
   task automatic do_search(input int budget, output int cyc, output bit ok);
      @(negedge clk); inicio = 1'b1;
      @(posedge clk); @(negedge clk); inicio = 1'b0;
      ok = 1'b0; cyc = 0;
      for (int k = 1; k <= budget; k++) begin
         @(posedge clk); @(negedge clk);
         if (term_v) begin cyc = k; ok = 1'b1; break; end
      end
      if (!ok) begin
         detener = 1'b1; @(negedge clk); detener = 1'b0;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      vectors++;
      if ({bus32.ocupado, bus32.terminado, bus32.encontrado, bus32.bounty, bus32.nonce_final} !== '0) begin
         miscompares++; $display("[TB] FAIL reset32 outputs got %h exp 0",
            {bus32.ocupado, bus32.terminado, bus32.encontrado, bus32.bounty, bus32.nonce_final});
      end
      vectors++;
      if ({bus8.ocupado, bus8.terminado, bus8.encontrado, bus8.bounty, bus8.nonce_final} !== '0) begin
         miscompares++; $display("[TB] FAIL reset8 outputs got %h exp 0",
            {bus8.ocupado, bus8.terminado, bus8.encontrado, bus8.bounty, bus8.nonce_final});
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_exhaustion;
      int cyc; bit ok;
      use8 = 1'b0;
      data_in = {$urandom, $urandom, $urandom, $urandom};
      nonce_in = 32'hFFFF_FFFE; target_in = 8'h00; modo_in = 1'b0;
      do_search(100, cyc, ok);
      vectors++; if (!ok || cyc != 68) begin miscompares++; $display("[TB] FAIL exhaust cycles got %0d exp 68", cyc); end
      vectors++; if (enc_v !== 1'b0) begin miscompares++; $display("[TB] FAIL exhaust encontrado got %b exp 0", enc_v); end
      vectors++; if (bounty_v !== 24'h0) begin miscompares++; $display("[TB] FAIL exhaust bounty got %h exp 0", bounty_v); end
      vectors++; if (nf_v !== 32'hFFFF_FFFF) begin miscompares++; $display("[TB] FAIL exhaust nonce_final got %h exp ffffffff", nf_v); end
      vectors++; if (ocup_v !== 1'b0) begin miscompares++; $display("[TB] FAIL exhaust ocupado got %b exp 0", ocup_v); end
   endtask

   task automatic test_target_ff;
      int cyc, tries; bit ok; logic found; logic [23:0] eh; logic [31:0] enf;
      use8 = 1'b0; data_in = '0; nonce_in = '0; target_in = 8'hFF; modo_in = 1'b0;
      model_search(32, data_in, nonce_in, target_in, modo_in, 300, found, eh, enf, tries);
      do_search(34 * tries + 10, cyc, ok);
      vectors++; if (!ok || cyc != 34 * tries) begin miscompares++; $display("[TB] FAIL tff cycles got %0d exp %0d", cyc, 34 * tries); end
      vectors++; if (enc_v !== found) begin miscompares++; $display("[TB] FAIL tff encontrado got %b exp %b", enc_v, found); end
      vectors++; if (bounty_v !== eh) begin miscompares++; $display("[TB] FAIL tff bounty got %h exp %h", bounty_v, eh); end
      vectors++; if (nf_v !== enf) begin miscompares++; $display("[TB] FAIL tff nonce_final got %h exp %h", nf_v, enf); end
      last_nf32 = enf;
   endtask

   task automatic test_abort;
      int cyc, tries, seen; bit ok; logic found; logic [23:0] eh; logic [31:0] enf;
      use8 = 1'b0;
      data_in = {$urandom, $urandom, $urandom, $urandom};
      nonce_in = $urandom; target_in = 8'h00; modo_in = 1'b0;
      @(negedge clk); inicio = 1'b1;
      @(posedge clk); @(negedge clk); inicio = 1'b0;
      for (int k = 1; k <= 20; k++) begin @(posedge clk); @(negedge clk); end
      vectors++; if (ocup_v !== 1'b1) begin miscompares++; $display("[TB] FAIL abort busy ocupado got %b exp 1", ocup_v); end
      detener = 1'b1;
      @(posedge clk); @(negedge clk); detener = 1'b0;
      vectors++; if (ocup_v !== 1'b0) begin miscompares++; $display("[TB] FAIL abort ocupado got %b exp 0", ocup_v); end
      vectors++; if (enc_v !== 1'b0 || bounty_v !== 24'h0) begin miscompares++; $display("[TB] FAIL abort enc/bounty got %b/%h exp 0/0", enc_v, bounty_v); end
      vectors++; if (nf_v !== last_nf32) begin miscompares++; $display("[TB] FAIL abort nonce_final got %h exp %h", nf_v, last_nf32); end
      seen = 0;
      repeat (80) begin @(negedge clk); if (term_v) seen++; end
      vectors++; if (seen != 0 || ocup_v !== 1'b0) begin miscompares++; $display("[TB] FAIL abort quiet terminado=%0d ocupado=%b exp 0/0", seen, ocup_v); end
      target_in = 8'hFF;
      model_search(32, data_in, nonce_in, target_in, modo_in, 300, found, eh, enf, tries);
      do_search(34 * tries + 10, cyc, ok);
      vectors++; if (!ok || cyc != 34 * tries) begin miscompares++; $display("[TB] FAIL rerun cycles got %0d exp %0d", cyc, 34 * tries); end
      vectors++; if (enc_v !== found || bounty_v !== eh || nf_v !== enf) begin
         miscompares++; $display("[TB] FAIL rerun result got %b/%h/%h exp %b/%h/%h", enc_v, bounty_v, nf_v, found, eh, enf);
      end
   endtask

   task automatic test_modo;
      int cyc, t0, t1; bit ok; logic f0, f1; logic [23:0] h0, h1; logic [31:0] n0, n1;
      use8 = 1'b0; target_in = 8'h40;
      do begin
         data_in = {$urandom, $urandom, $urandom, $urandom};
         nonce_in = $urandom;
         model_search(32, data_in, nonce_in, 8'h40, 1'b0, 250, f0, h0, n0, t0);
         model_search(32, data_in, nonce_in, 8'h40, 1'b1, 250, f1, h1, n1, t1);
      end while (t0 > 250 || t1 > 250);
      modo_in = 1'b0;
      do_search(34 * t0 + 10, cyc, ok);
      vectors++; if (!ok || cyc != 34 * t0) begin miscompares++; $display("[TB] FAIL modo0 cycles got %0d exp %0d", cyc, 34 * t0); end
      vectors++; if (enc_v !== f0 || bounty_v !== h0 || nf_v !== n0) begin
         miscompares++; $display("[TB] FAIL modo0 result got %b/%h/%h exp %b/%h/%h", enc_v, bounty_v, nf_v, f0, h0, n0);
      end
      modo_in = 1'b1;
      do_search(34 * t1 + 10, cyc, ok);
      vectors++; if (!ok || cyc != 34 * t1) begin miscompares++; $display("[TB] FAIL modo1 cycles got %0d exp %0d", cyc, 34 * t1); end
      vectors++; if (enc_v !== f1 || bounty_v !== h1 || nf_v !== n1) begin
         miscompares++; $display("[TB] FAIL modo1 result got %b/%h/%h exp %b/%h/%h", enc_v, bounty_v, nf_v, f1, h1, n1);
      end
      vectors++; if (nf_v < n0) begin miscompares++; $display("[TB] FAIL modo order got %h exp >= %h", nf_v, n0); end
   endtask

   task automatic test_back_to_back;
      int tries, first, second; logic found; logic [23:0] eh; logic [31:0] enf;
      use8 = 1'b0; target_in = 8'hFF; modo_in = 1'b0;
      do begin
         data_in = {$urandom, $urandom, $urandom, $urandom};
         nonce_in = $urandom;
         model_search(32, data_in, nonce_in, target_in, modo_in, 20, found, eh, enf, tries);
      end while (tries > 20);
      first = 0; second = 0;
      @(negedge clk); inicio = 1'b1;
      @(posedge clk); @(negedge clk);
      for (int k = 1; k <= 68 * tries + 20; k++) begin
         @(posedge clk); @(negedge clk);
         if (term_v) begin
            if (first == 0) begin
               first = k;
               vectors++; if (ocup_v !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b gap ocupado got %b exp 0", ocup_v); end
            end else begin
               second = k; inicio = 1'b0; break;
            end
         end
      end
      inicio = 1'b0;
      vectors++; if (first != 34 * tries) begin miscompares++; $display("[TB] FAIL b2b first got %0d exp %0d", first, 34 * tries); end
      vectors++; if (second != 68 * tries + 1) begin miscompares++; $display("[TB] FAIL b2b second got %0d exp %0d", second, 68 * tries + 1); end
      vectors++; if (enc_v !== found || bounty_v !== eh || nf_v !== enf) begin
         miscompares++; $display("[TB] FAIL b2b result got %b/%h/%h exp %b/%h/%h", enc_v, bounty_v, nf_v, found, eh, enf);
      end
      if (second == 0) begin detener = 1'b1; @(negedge clk); detener = 1'b0; end
      repeat (2) @(negedge clk);
      vectors++; if (ocup_v !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b idle ocupado got %b exp 0", ocup_v); end
   endtask

   task automatic test_random;
      int cyc, tries, nw; bit ok; logic found; logic [23:0] eh; logic [31:0] enf;
      for (int it = 0; it < 8; it++) begin
         use8 = it[0];
         nw = use8 ? 8 : 32;
         do begin
            data_in = {$urandom, $urandom, $urandom, $urandom};
            nonce_in = use8 ? 32'($urandom_range(255, 200)) : $urandom;
            target_in = 8'($urandom_range(255, 96));
            modo_in = 1'($urandom_range(1, 0));
            model_search(nw, data_in, nonce_in, target_in, modo_in, 100, found, eh, enf, tries);
         end while (tries > 100);
         do_search(34 * tries + 10, cyc, ok);
         vectors++; if (!ok || cyc != 34 * tries) begin miscompares++; $display("[TB] FAIL rand%0d cycles got %0d exp %0d", it, cyc, 34 * tries); end
         vectors++; if (enc_v !== found || bounty_v !== eh || nf_v !== enf) begin
            miscompares++; $display("[TB] FAIL rand%0d result got %b/%h/%h exp %b/%h/%h", it, enc_v, bounty_v, nf_v, found, eh, enf);
         end
      end
      use8 = 1'b0;
   endtask

   task automatic test_nonce8_no_wrap;
      int cyc, seen; bit ok;
      use8 = 1'b1;
      data_in = {$urandom, $urandom, $urandom, $urandom};
      nonce_in = 32'h0000_00FE; target_in = 8'h00; modo_in = 1'b0;
      do_search(100, cyc, ok);
      vectors++; if (!ok || cyc != 68) begin miscompares++; $display("[TB] FAIL n8 cycles got %0d exp 68", cyc); end
      vectors++; if (nf_v !== 32'h0000_00FF) begin miscompares++; $display("[TB] FAIL n8 nonce_final got %h exp ff", nf_v); end
      vectors++; if (enc_v !== 1'b0 || bounty_v !== 24'h0) begin miscompares++; $display("[TB] FAIL n8 enc/bounty got %b/%h exp 0/0", enc_v, bounty_v); end
      seen = 0;
      repeat (50) begin @(negedge clk); if (term_v || ocup_v) seen++; end
      vectors++; if (seen != 0) begin miscompares++; $display("[TB] FAIL n8 wrap activity got %0d exp 0", seen); end
      use8 = 1'b0;
   endtask

   task automatic test_reset_mid_search;
      int seen;
      use8 = 1'b0;
      data_in = {$urandom, $urandom, $urandom, $urandom};
      nonce_in = $urandom; target_in = 8'hFF; modo_in = 1'b1;
      @(negedge clk); inicio = 1'b1;
      @(posedge clk); @(negedge clk); inicio = 1'b0;
      repeat (10) begin @(posedge clk); @(negedge clk); end
      vectors++; if (ocup_v !== 1'b1) begin miscompares++; $display("[TB] FAIL rst-mid busy got %b exp 1", ocup_v); end
      #2 reset = 1'b1;
      #1;
      vectors++;
      if ({bus32.ocupado, bus32.terminado, bus32.encontrado, bus32.bounty, bus32.nonce_final} !== '0) begin
         miscompares++; $display("[TB] FAIL rst-mid outputs got %h exp 0",
            {bus32.ocupado, bus32.terminado, bus32.encontrado, bus32.bounty, bus32.nonce_final});
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      seen = 0;
      repeat (40) begin @(negedge clk); if (term_v || ocup_v) seen++; end
      vectors++; if (seen != 0) begin miscompares++; $display("[TB] FAIL rst-mid activity got %0d exp 0", seen); end
   endtask

   initial begin
      test_reset();
      test_exhaustion();
      test_target_ff();
      test_abort();
      test_modo();
      test_back_to_back();
      test_random();
      test_nonce8_no_wrap();
      test_reset_mid_search();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
